// File: rtl/exe_unit_param.sv
// Execute stage: register file, NZP condition codes, ALU/branch/call/return and
// an optional multi-cycle multiply, with valid/ready on both input and output.
module exe_unit_param #(
  parameter int DW         = 16,
  parameter int NREG       = 8,
  parameter int RAW        = $clog2(NREG),
  parameter int MUL_EN     = 1,
  parameter int MUL_CYCLES = 4,
  parameter int LINK_REG   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4:0]     op_type,
  input  logic [1:0]     alu_op,
  input  logic [RAW-1:0] sr1,
  input  logic [RAW-1:0] sr2,
  input  logic [RAW-1:0] dr,
  input  logic [DW-1:0]  imm,
  input  logic [DW-1:0]  ip,
  input  logic [2:0]     nzp_mask,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  next_ip,
  output logic           redirect,
  output logic           wb_en,
  output logic [RAW-1:0] wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic [2:0]     cc,
  output logic           busy,
  output logic [1:0]     state_dbg
);

  // Handshake: an op transfers on a clock edge where in_valid && in_ready; a
  // result transfers on an edge where out_valid && out_ready. A held result
  // keeps every output stable until it transfers.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [4:0] T_RET  = 5'b00000;
  localparam logic [4:0] T_NOT  = 5'b00100;
  localparam logic [4:0] T_LDI  = 5'b00101;
  localparam logic [4:0] T_RR   = 5'b00110;
  localparam logic [4:0] T_RI   = 5'b00111;
  localparam logic [4:0] T_BR   = 5'b01001;
  localparam logic [4:0] T_CALL = 5'b10001;

  localparam int            CW        = $clog2(MUL_CYCLES + 1);
  localparam logic [RAW-1:0] LINK_ADDR = RAW'(LINK_REG);
  localparam logic [DW-1:0]  ONE       = {{(DW-1){1'b0}}, 1'b1};

  state_t          state;
  logic [CW-1:0]   mul_cnt;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   mul_a, mul_b, mul_ip, mul_prod;
  logic [RAW-1:0]  mul_dr;

  logic            accept, is_mul, br_taken;
  logic [DW-1:0]   op_a, op_b, alu_res, seq_ip;
  logic            c_we, c_upd, c_red;
  logic [RAW-1:0]  c_wa;
  logic [DW-1:0]   c_wd, c_nip;

  function automatic logic [2:0] cc_of(input logic [DW-1:0] v);
    if (v[DW-1])      return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  // rst_n is an active-high reset: nothing is accepted while it is asserted.
  assign in_ready  = !rst_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign is_mul    = (MUL_EN != 0) && ((op_type == T_RR) || (op_type == T_RI)) && (alu_op == 2'b11);
  assign mul_prod  = mul_a * mul_b;

  always_comb begin
    op_a     = regs[sr1];
    op_b     = (op_type == T_RI) ? imm : regs[sr2];
    seq_ip   = ip + ONE;
    br_taken = |(nzp_mask & cc);
    case (alu_op)
      2'b01:   alu_res = op_a & op_b;
      2'b10:   alu_res = op_a - op_b;
      default: alu_res = op_a + op_b;  // MUL encoding lands here only when MUL_EN = 0
    endcase
    c_we  = 1'b0;
    c_upd = 1'b0;
    c_red = 1'b0;
    c_wa  = dr;
    c_wd  = alu_res;
    c_nip = seq_ip;
    case (op_type)
      T_RR, T_RI: begin c_we = 1'b1; c_upd = 1'b1; end
      T_NOT:      begin c_we = 1'b1; c_upd = 1'b1; c_wd = ~op_a; end
      T_LDI:      begin c_we = 1'b1; c_upd = 1'b1; c_wd = imm; end
      T_BR: begin
        if (br_taken) begin
          c_red = 1'b1;
          c_nip = seq_ip + imm;
        end
      end
      T_CALL: begin
        c_we  = 1'b1;
        c_wa  = LINK_ADDR;
        c_wd  = seq_ip;
        c_red = 1'b1;
        c_nip = seq_ip + imm;
      end
      T_RET:   begin c_red = 1'b1; c_nip = op_a; end
      default: ;
    endcase
    if (!c_we) begin
      c_wa = '0;
      c_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= S_IDLE;
      mul_cnt  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cc       <= 3'b010;
      next_ip  <= '0;
      redirect <= 1'b0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ip   <= '0;
      mul_dr   <= '0;
    end else if (accept) begin
      if (is_mul) begin
        state   <= S_MUL;
        mul_cnt <= CW'(MUL_CYCLES - 1);
        mul_a   <= op_a;
        mul_b   <= op_b;
        mul_dr  <= dr;
        mul_ip  <= seq_ip;
      end else begin
        if (c_we)  regs[c_wa] <= c_wd;
        if (c_upd) cc <= cc_of(c_wd);
        next_ip  <= c_nip;
        redirect <= c_red;
        wb_en    <= c_we;
        wb_addr  <= c_wa;
        wb_data  <= c_wd;
        state    <= S_DONE;
      end
    end else begin
      case (state)
        S_MUL: begin
          // Commit on the edge that would take the count to zero, so the
          // result is visible exactly MUL_CYCLES cycles after accept.
          if (mul_cnt <= CW'(1)) begin
            regs[mul_dr] <= mul_prod;
            cc           <= cc_of(mul_prod);
            next_ip      <= mul_ip;
            redirect     <= 1'b0;
            wb_en        <= 1'b1;
            wb_addr      <= mul_dr;
            wb_data      <= mul_prod;
            state        <= S_DONE;
          end else begin
            mul_cnt <= mul_cnt - CW'(1);
          end
        end
        S_DONE:  if (out_ready) state <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_param.sv
// Bench for exe_unit_param: directed scenarios plus random ops, checked against
// an architectural model of the register file, condition codes and next IP.
module tb_exe_unit_param;
  localparam int DW = 16, NREG = 8, RAW = 3, W = 40;

  localparam logic [4:0] T_RET  = 5'b00000;
  localparam logic [4:0] T_NOT  = 5'b00100;
  localparam logic [4:0] T_LDI  = 5'b00101;
  localparam logic [4:0] T_RR   = 5'b00110;
  localparam logic [4:0] T_RI   = 5'b00111;
  localparam logic [4:0] T_BR   = 5'b01001;
  localparam logic [4:0] T_CALL = 5'b10001;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst_n, in_valid, out_ready, sel_b;
  logic [4:0]     op_type;
  logic [1:0]     alu_op;
  logic [RAW-1:0] sr1, sr2, dr;
  logic [DW-1:0]  imm, ip;
  logic [2:0]     nzp_mask;

  logic           a_in_ready, a_out_valid, a_redirect, a_wb_en, a_busy;
  logic [DW-1:0]  a_next_ip, a_wb_data;
  logic [RAW-1:0] a_wb_addr;
  logic [2:0]     a_cc;
  logic [1:0]     a_state;
  logic           b_in_ready, b_out_valid, b_redirect, b_wb_en, b_busy;
  logic [DW-1:0]  b_next_ip, b_wb_data;
  logic [RAW-1:0] b_wb_addr;
  logic [2:0]     b_cc;
  logic [1:0]     b_state;

  logic in_valid_a, in_valid_b;
  assign in_valid_a = in_valid & ~sel_b;
  assign in_valid_b = in_valid & sel_b;

  exe_unit_param #(.MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(a_in_ready),
    .op_type(op_type), .alu_op(alu_op), .sr1(sr1), .sr2(sr2), .dr(dr),
    .imm(imm), .ip(ip), .nzp_mask(nzp_mask), .out_valid(a_out_valid),
    .out_ready(out_ready), .next_ip(a_next_ip), .redirect(a_redirect),
    .wb_en(a_wb_en), .wb_addr(a_wb_addr), .wb_data(a_wb_data), .cc(a_cc),
    .busy(a_busy), .state_dbg(a_state)
  );

  exe_unit_param #(.MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(b_in_ready),
    .op_type(op_type), .alu_op(alu_op), .sr1(sr1), .sr2(sr2), .dr(dr),
    .imm(imm), .ip(ip), .nzp_mask(nzp_mask), .out_valid(b_out_valid),
    .out_ready(out_ready), .next_ip(b_next_ip), .redirect(b_redirect),
    .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data), .cc(b_cc),
    .busy(b_busy), .state_dbg(b_state)
  );

  logic           o_in_ready, o_out_valid, o_redirect, o_wb_en, o_busy;
  logic [DW-1:0]  o_next_ip, o_wb_data;
  logic [RAW-1:0] o_wb_addr;
  logic [2:0]     o_cc;
  assign o_in_ready  = sel_b ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel_b ? b_out_valid : a_out_valid;
  assign o_redirect  = sel_b ? b_redirect  : a_redirect;
  assign o_wb_en     = sel_b ? b_wb_en     : a_wb_en;
  assign o_busy      = sel_b ? b_busy      : a_busy;
  assign o_next_ip   = sel_b ? b_next_ip   : a_next_ip;
  assign o_wb_data   = sel_b ? b_wb_data   : a_wb_data;
  assign o_wb_addr   = sel_b ? b_wb_addr   : a_wb_addr;
  assign o_cc        = sel_b ? b_cc        : a_cc;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           n_cmp = 0, n_err = 0;

  // reference model: one architectural state per instance (0 = MUL_EN=1, 1 = MUL_EN=0)
  logic [DW-1:0] m_regs [2][NREG];
  logic [2:0]    m_cc [2];
  int            m_mul_en [2] = '{1, 0};
  logic [4:0]    types [9] = '{T_RR, T_RI, T_NOT, T_LDI, T_BR, T_CALL, T_RET, 5'b01111, 5'b11111};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] obs_pack();
    return {o_next_ip, o_redirect, o_wb_en, o_wb_en ? o_wb_addr : 3'd0,
            o_wb_en ? o_wb_data : 16'd0, o_cc};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < NREG; r++) m_regs[s][r] = '0;
      m_cc[s] = 3'b010;
    end
    exp_q.delete(); lat_q.delete(); acc_q.delete();
  endtask

  task automatic model_exec(input int s, input logic [4:0] t, input logic [1:0] aop,
                            input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                            input logic [15:0] im, input logic [15:0] ipv, input logic [2:0] mask,
                            output logic [W-1:0] e, output int lat);
    logic [15:0] a, b, nip, wd;
    logic [31:0] prod;
    logic [2:0]  wa;
    logic        red, we;
    a = m_regs[s][s1];
    b = (t == T_RI) ? im : m_regs[s][s2];
    nip = ipv + 16'd1; red = 0; we = 0; wa = 0; wd = 0; lat = 1;
    case (t)
      T_RR, T_RI: begin
        we = 1; wa = d;
        case (aop)
          2'd0: wd = a + b;
          2'd1: wd = a & b;
          2'd2: wd = a - b;
          default: begin
            if (m_mul_en[s] != 0) begin
              prod = a * b;
              wd = prod[15:0];
              lat = 4;
            end else wd = a + b;
          end
        endcase
      end
      T_NOT: begin we = 1; wa = d; wd = ~a; end
      T_LDI: begin we = 1; wa = d; wd = im; end
      T_BR:  if ((mask & m_cc[s]) != 0) begin nip = ipv + 16'd1 + im; red = 1; end
      T_CALL: begin we = 1; wa = 3'd7; wd = ipv + 16'd1; nip = ipv + 16'd1 + im; red = 1; end
      T_RET: begin nip = a; red = 1; end
      default: ;
    endcase
    if (we) begin
      m_regs[s][wa] = wd;
      if (t != T_CALL) m_cc[s] = wd[15] ? 3'b100 : (wd == 0 ? 3'b010 : 3'b001);
    end
    e = {nip, red, we, wa, wd, m_cc[s]};
  endtask

  // driver: present an op at a negedge and hold it until it is accepted
  task automatic issue(input logic [4:0] t, input logic [1:0] aop, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [2:0] d, input logic [15:0] im,
                       input logic [15:0] ipv, input logic [2:0] mask, output int waited);
    logic [W-1:0] e;
    int lat;
    op_type = t; alu_op = aop; sr1 = s1; sr2 = s2; dr = d;
    imm = im; ip = ipv; nzp_mask = mask; in_valid = 1'b1;
    #1;
    waited = 0;
    while (!o_in_ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      model_exec(sel_b ? 1 : 0, t, aop, s1, s2, d, im, ipv, mask, e, lat);
      exp_q.push_back(e);
      lat_q.push_back(lat);
      @(posedge clk); #1;
      acc_q.push_back(cyc);
    end
  endtask

  // wait for the next result, compare it and its latency, optionally stall it
  task automatic check_result(input string tag, input int hold);
    int w;
    logic [W-1:0] e;
    int l, a;
    w = 0;
    while (!o_out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100 || exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: out_valid stayed 0, required 1", tag);
    end else begin
      e = exp_q.pop_front(); l = lat_q.pop_front(); a = acc_q.pop_front();
      chk(tag, obs_pack(), e);
      chk({tag, "_lat"}, W'(cyc - a + 1), W'(l));
      if (hold > 0) begin
        out_ready = 1'b0;
        repeat (hold) @(negedge clk);
        chk({tag, "_held"}, obs_pack(), e);
        chk({tag, "_held_valid"}, W'(o_out_valid), W'(1));
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic run(input string tag, input logic [4:0] t, input logic [1:0] aop,
                     input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                     input logic [15:0] im, input logic [15:0] ipv, input logic [2:0] mask,
                     input int hold);
    int w;
    issue(t, aop, s1, s2, d, im, ipv, mask, w);
    @(negedge clk);
    in_valid = 1'b0;
    check_result(tag, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel_b = 1'b0;
    op_type = '0; alu_op = '0; sr1 = '0; sr2 = '0; dr = '0;
    imm = '0; ip = '0; nzp_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(a_in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", obs_pack(), {16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 3'b010});
    chk("rst_wb_raw", W'({a_wb_addr, a_wb_data}), W'(0));
    chk("rst_valid_busy", W'({a_out_valid, a_busy}), W'(0));
    chk("rst_release_ready", W'(a_in_ready), W'(1));

    // back-to-back LDI then ADD immediate
    issue(T_LDI, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0005, 16'h0000, 3'd0, w);
    @(negedge clk);
    check_result("ldi_r1", 0);
    issue(T_RI, 2'd0, 3'd1, 3'd0, 3'd2, 16'hFFFA, 16'h0001, 3'd0, w);
    chk("b2b_no_stall", W'(w), W'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("addi_direct", W'({o_wb_data, o_cc}), W'({16'hFFFF, 3'b100}));
    check_result("addi", 0);

    // SUB to zero, then branch taken / not taken
    run("ldi_r3", T_LDI, 2'd0, 3'd0, 3'd0, 3'd3, 16'h0007, 16'h0002, 3'd0, 0);
    run("ldi_r4", T_LDI, 2'd0, 3'd0, 3'd0, 3'd4, 16'h0007, 16'h0003, 3'd0, 0);
    run("sub_zero", T_RR, 2'd2, 3'd3, 3'd4, 3'd5, 16'h0000, 16'h0004, 3'd0, 0);
    run("br_taken", T_BR, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0004, 16'h0010, 3'b010, 0);
    run("br_not_taken", T_BR, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0004, 16'h0010, 3'b101, 0);

    // CALL / RET
    run("call", T_CALL, 2'd0, 3'd0, 3'd0, 3'd0, 16'hFFF0, 16'h0020, 3'd0, 0);
    issue(T_RET, 2'd0, 3'd7, 3'd0, 3'd0, 16'h0000, 16'h0011, 3'd0, w);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ret_direct", W'({o_next_ip, o_redirect}), W'({16'h0021, 1'b1}));
    check_result("ret", 0);

    // multi-cycle MUL on the MUL_EN=1 instance
    run("ldi_m1", T_LDI, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0100, 16'h0030, 3'd0, 0);
    run("ldi_m2", T_LDI, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0101, 16'h0031, 3'd0, 0);
    issue(T_RR, 2'd3, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0032, 3'd0, w);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy_ready", W'({o_busy, o_in_ready, o_out_valid}), W'(3'b100));
      @(negedge clk);
    end
    check_result("mul", 0);

    // same sequence on the MUL_EN=0 instance executes as ADD
    sel_b = 1'b1;
    run("nm_ldi_m1", T_LDI, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0100, 16'h0030, 3'd0, 0);
    run("nm_ldi_m2", T_LDI, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0101, 16'h0031, 3'd0, 0);
    issue(T_RR, 2'd3, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0032, 3'd0, w);
    @(negedge clk);
    in_valid = 1'b0;
    chk("nm_mul_as_add", W'(o_wb_data), W'(16'h0201));
    check_result("nm_mul", 0);
    sel_b = 1'b0;

    // back-pressure: result held for 5 cycles while another op waits
    issue(T_RI, 2'd1, 3'd2, 3'd0, 3'd4, 16'h0F0F, 16'h0040, 3'd0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      op_type = T_LDI; dr = 3'd4; imm = 16'h1234; ip = 16'h0041; in_valid = 1'b1;
      #1;
      chk("hold_outputs", obs_pack(), exp_q[0]);
      chk("hold_ready_valid", W'({o_in_ready, o_out_valid}), W'(2'b01));
    end
    @(negedge clk);
    chk("hold_final", obs_pack(), exp_q[0]);
    void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(acc_q.pop_front());
    out_ready = 1'b1;
    issue(T_LDI, 2'd0, 3'd0, 3'd0, 3'd4, 16'h1234, 16'h0041, 3'd0, w);
    chk("release_same_cycle", W'(w), W'(0));
    @(negedge clk);
    in_valid = 1'b0;
    check_result("after_release", 0);
    run("read_r4", T_RI, 2'd0, 3'd4, 3'd0, 3'd5, 16'h0000, 16'h0042, 3'd0, 0);

    // reset during cycle 2 of a MUL
    run("ldi_x1", T_LDI, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0003, 16'h0050, 3'd0, 0);
    issue(T_RR, 2'd3, 3'd1, 3'd1, 3'd6, 16'h0000, 16'h0051, 3'd0, w);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_rst_ready", W'({a_in_ready, a_out_valid, a_busy}), W'(0));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midmul_rst_outputs", obs_pack(), {16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 3'b010});
    issue(T_RI, 2'd0, 3'd6, 3'd0, 3'd6, 16'h0000, 16'h0060, 3'd0, w);
    chk("post_rst_accept", W'(w), W'(0));
    @(negedge clk);
    in_valid = 1'b0;
    check_result("midmul_dest_zero", 0);

    // random ops against the model, with random instance and back-pressure
    for (int k = 0; k < 200; k++) begin
      logic [4:0] t;
      int hold;
      sel_b = ($urandom_range(0, 3) == 0);
      t = types[$urandom_range(0, 8)];
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run("rnd", t, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), hold);
    end
    sel_b = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_unit_param.md
Name: exe_unit_param

Overview:
Parametrised next-generation execute stage for the 16-bit CPU core.
- Owns an NREG x DW register file and NZP condition codes.
- Executes ALU, load-immediate, branch, call and return operations from the decoder over a valid/ready handshake.
- Returns the next IP to fetch with a redirect flag.
- Adds an optional multi-cycle multiply and output back-pressure, neither of which the previous execute stage had.

Parameters:
DW, 16, datapath/IP width
NREG, 8, number of general registers
RAW, $clog2(NREG), register address width
MUL_EN, 1, 1 enables MUL; 0 executes MUL encodings as ADD
MUL_CYCLES, 4, MUL latency in cycles (>=2)
LINK_REG, 7, register receiving the return address on CALL

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (asserted = 1)
in_valid  in  1  decoder has an op
in_ready  out  1  unit accepts op this cycle
type  in  5  op class
alu_op  in  2  00 ADD, 01 AND, 10 SUB, 11 MUL
sr1  in  RAW  source 1
sr2  in  RAW  source 2
dr  in  RAW  destination
imm  in  DW  sign-extended immediate/offset
ip  in  DW  IP of op
nzp_mask  in  3  branch condition {n,z,p}
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
next_ip  out  DW  next fetch address
redirect  out  1  next_ip is not ip+1
wb_en  out  1  op wrote a register
wb_addr  out  RAW  register written
wb_data  out  DW  value written
cc  out  3  current {n,z,p}
busy  out  1  state != IDLE

Behaviour:
Type decode (any other code is NOP: next_ip = ip+1, no write, cc unchanged):
- 00110 ALU_RR: R[dr] = R[sr1] op R[sr2].
- 00111 ALU_RI: R[dr] = R[sr1] op imm.
- 00100 NOT: R[dr] = ~R[sr1].
- 00101 LDI: R[dr] = imm.
- 01001 BR: taken if (nzp_mask & cc) != 0. Taken: next_ip = ip+1+imm, redirect = 1. Not taken: next_ip = ip+1, redirect = 0. No write.
- 10001 CALL: R[LINK_REG] = ip+1; next_ip = ip+1+imm; redirect = 1; cc unchanged.
- 00000 RET: next_ip = R[sr1]; redirect = 1; no write.
- All non-redirecting ops: next_ip = ip+1, redirect = 0.

Arithmetic:
- Everything modulo 2^DW.
- SUB = R[sr1] - operand2.
- MUL = low DW bits of the product.
- imm is used as given; this block does no extension.

Condition codes:
- Updated by ALU_RR, ALU_RI, NOT and LDI from the written value: n = msb, z = (value == 0), p otherwise.
- Exactly one bit is ever set.

FSM states: IDLE, MUL, DONE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Accept = in_valid && in_ready. Operands and ip are read combinationally from the register file and latched at accept.
- Non-MUL accept: compute in the same cycle. On that edge: register write, cc update, output registers load, state -> DONE. out_valid is high on the next cycle (latency 1).
- MUL accept (MUL_EN = 1): state -> MUL with counter = MUL_CYCLES-1. Counter decrements each cycle. At 0: write, cc update and output load happen, state -> DONE. out_valid rises MUL_CYCLES cycles after accept.
- DONE: out_valid = 1. Outputs hold stable while out_ready = 0.
  - out_ready && in_valid: the new op is accepted in the same cycle. It sees the previous op's write already committed, so no forwarding is needed. Result: back-to-back throughput of 1 op/cycle.
  - out_ready && !in_valid: state -> IDLE, out_valid falls.
- Ops whose sr1/sr2 equals the destination of the op in DONE read the new value.
- dr == LINK_REG on ALU ops is legal.
- Register write and cc update occur exactly once per op, never at handshake time.

Reset (rst_n = 1 on a clk edge), including mid-MUL or mid-DONE:
- Abandon the in-flight op without committing its write. state = IDLE.
- All registers = 0. cc = 3'b010.
- out_valid = 0, redirect = 0, wb_en = 0, wb_addr = 0, wb_data = 0, next_ip = 0, busy = 0.
- in_ready = 0 during reset, 1 on the first cycle after it.

Test Plan:
- LDI dr=1 imm=0x0005, then ALU_RI ADD sr1=1 imm=0xFFFA dr=2 back-to-back with out_ready=1 -> second result wb_data=0xFFFF, cc=100, one op retired per cycle.
- ALU_RR SUB R3=0x0007, R4=0x0007, dr=5 -> wb_data=0x0000, cc=010. Then BR nzp_mask=010, ip=0x0010, imm=0x0004 -> next_ip=0x0015, redirect=1. Same BR with mask=101 -> next_ip=0x0011, redirect=0.
- CALL ip=0x0020 imm=0xFFF0 -> R7=0x0021, next_ip=0x0011, cc unchanged. Then RET sr1=7 -> next_ip=0x0021, redirect=1.
- MUL R1=0x0100, R2=0x0101 -> out_valid exactly 4 cycles after accept, wb_data=0x0100, busy=1 and in_ready=0 during MUL. With MUL_EN=0 the same op yields 0x0201 at latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, no further register change. Release -> retire in the same cycle.
- Assert rst_n during cycle 2 of a MUL -> destination register stays 0, cc=010, out_valid=0, next op accepted on the cycle after reset is released.
